// File: rtl/rv32i_types.sv
// rv32i_types: shared core types, including the common data bus (CDB) result and broadcast bundles.
package rv32i_types;
    localparam int ROB_IDX_W  = 5;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [ROB_IDX_W-1:0]  rob_idx;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  regf_we;
        logic [XLEN-1:0]       data;
    } cdb_req_t;

    typedef struct packed {
        logic     valid;
        cdb_req_t payload;
    } cdb_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority selector; ptr names the highest-priority requester.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbitration of functional-unit results onto the registered CDB.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int N_REQ         = 4,
    parameter int ROB_IDX_WIDTH = ROB_IDX_W,
    parameter int DATA_WIDTH    = XLEN,
    parameter int SW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [N_REQ-1:0]                     req_valid,
    output logic [N_REQ-1:0]                     req_ready,
    input  logic [N_REQ-1:0][ROB_IDX_WIDTH-1:0]  req_rob_idx,
    input  logic [N_REQ-1:0][4:0]                req_rd_addr,
    input  logic [N_REQ-1:0]                     req_regf_we,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     req_data,
    output logic                                 cdb_valid,
    output logic [ROB_IDX_WIDTH-1:0]             cdb_rob_idx,
    output logic [4:0]                           cdb_rd_addr,
    output logic                                 cdb_regf_we,
    output logic [DATA_WIDTH-1:0]                cdb_data,
    output logic [SW-1:0]                        cdb_src
);
    logic [SW-1:0]    ptr;
    logic [N_REQ-1:0] gnt;
    logic [SW-1:0]    idx;
    logic             any;
    logic             xfer;
    cdb_req_t         sel;
    cdb_t             cdb;

    rr_arbiter #(.N(N_REQ), .IW(SW)) u_rr (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );

    // Ready is withheld during reset and flush, so nothing can be captured then.
    always_comb begin
        xfer      = any && !rst && !flush;
        req_ready = xfer ? gnt : '0;
        sel       = '{rob_idx: req_rob_idx[idx],
                      rd_addr: req_rd_addr[idx],
                      regf_we: req_regf_we[idx] && (req_rd_addr[idx] != '0),
                      data:    req_data[idx]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb     <= '0;
            cdb_src <= '0;
            ptr     <= '0;
        end else begin
            cdb.valid <= xfer;
            if (xfer) begin
                cdb.payload <= sel;
                cdb_src     <= idx;
                ptr         <= (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
            end
        end
    end

    assign cdb_valid   = cdb.valid;
    assign cdb_rob_idx = cdb.payload.rob_idx;
    assign cdb_rd_addr = cdb.payload.rd_addr;
    assign cdb_regf_we = cdb.payload.regf_we;
    assign cdb_data    = cdb.payload.data;
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) between the out-of-order core's functional units (ALU, MUL, DIV, LSU). It accepts at most one completed result per cycle over a valid/ready handshake. It registers the winning result onto the CDB, which the ROB, reservation stations and rename table/ARF snoop. Fairness is guaranteed, so no unit is starved while another streams results.

## Interface
- N_REQ, 4, number of requesting functional units (index 0 = ALU, 1 = MUL, 2 = DIV, 3 = LSU)
- ROB_IDX_WIDTH, 5, ROB index width
- DATA_WIDTH, 32, result width

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush (mispredict); kills pending broadcast
- req_valid  in  N_REQ  per-unit result valid
- req_ready  out  N_REQ  per-unit grant; one-hot or zero
- req_rob_idx  in  N_REQ x ROB_IDX_WIDTH  result ROB index
- req_rd_addr  in  N_REQ x 5  destination arch register
- req_regf_we  in  N_REQ  result writes a register
- req_data  in  N_REQ x DATA_WIDTH  result value
- cdb_valid  out  1  broadcast valid
- cdb_rob_idx  out  ROB_IDX_WIDTH  broadcast ROB index
- cdb_rd_addr  out  5  broadcast rd
- cdb_regf_we  out  1  broadcast write enable; forced 0 when rd = x0
- cdb_data  out  DATA_WIDTH  broadcast value
- cdb_src  out  clog2(N_REQ)  index of the unit that produced the current broadcast

## Operation
- The rotating pointer `ptr` (clog2(N_REQ) bits) names the highest-priority requester.
- Grant: first i scanning ptr, ptr+1, … modulo N_REQ with req_valid[i]=1. req_ready is one-hot on that i, combinational from req_valid and ptr.
- When flush=1 or rst=1, req_ready is all-zero and no transfer occurs.
- Transfer: req_valid[i] & req_ready[i]. The payload is captured into the output register and ptr becomes (i+1) mod N_REQ.
- No transfer in a cycle: cdb_valid goes 0 next cycle. ptr and the cdb_* payload fields hold their values.
- The payload fields do not need to be cleared when idle; consumers qualify with cdb_valid.
- cdb_regf_we = req_regf_we[i] & (req_rd_addr[i] != 0).
- Requester rule: once req_valid[i] is raised, it stays high and the payload stays stable until granted. A bench assertion checks this.
- Fairness: a continuously valid requester is granted within N_REQ cycles.
- Flush: the cdb_valid register is cleared next cycle. A result captured in the same cycle as flush cannot occur, because ready is 0 during flush. Requesters drop their own valids.

## Timing
- Reset values: cdb_valid=0, cdb_rob_idx=0, cdb_rd_addr=0, cdb_regf_we=0, cdb_data=0, cdb_src=0, ptr=0. req_ready=0 during rst.
- Latency: a result granted in cycle t is on the CDB in cycle t+1, for exactly one cycle.
- Throughput: one broadcast per cycle, sustained.
- Wrap-around: grant N_REQ-1 sets ptr to 0.
- Single requester: granted every cycle it is valid, regardless of ptr.
- Flush asserted while cdb_valid=1: that broadcast stays visible for its cycle. The next cycle's cdb_valid is 0.
- Reset mid-stream: all state returns to reset values on the next edge, and any in-flight grant is lost.

## Structure
- Shared package rv32i_types gets the typedef cdb_req_t {rob_idx, rd_addr, regf_we, data}. The existing cdb struct is reused for the output bundle at the top level.
- Sub-module rr_arbiter: purely combinational rotating-priority one-hot selector (inputs req vector and ptr; outputs grant one-hot and grant index).
- cdb_arbiter owns ptr, the output register and the flush/reset gating.

## Test plan
- Reset, then all idle → req_ready=0 and cdb_valid=0 every cycle; all outputs 0.
- Only MUL valid (rob_idx=7, rd=5, data=0xDEADBEEF) → req_ready=0b0010 the same cycle; next cycle cdb_valid=1, rob_idx=7, rd=5, data=0xDEADBEEF, cdb_src=1.
- All four valid continuously from ptr=0 → grant order 0,1,2,3,0; cdb_src sequence 0,1,2,3,0 starting one cycle later; no bubbles.
- ALU result with rd=0 and regf_we=1 → cdb_regf_we=0, cdb_valid=1.
- flush=1 with ALU and LSU valid → req_ready=0, cdb_valid=0 next cycle, ptr unchanged; after flush drops, ALU (ptr=0) is granted first.
- Pointer at 3 with units 0 and 2 valid → unit 0 granted (wrap), then unit 2; assert hold-stability of unit 2's payload across the wait.
